axis_pkt_acc: RTL and testbench

Packet accumulator that sits directly downstream of the AXI-Stream adder stage. It consumes the adder's sum stream, delimited by tlast, and accumulates every beat of a packet. It emits one result beat per packet carrying the packet total, the beat count and a sticky overflow flag. Full handshake on both sides, with no bubble between packets when the downstream is ready.

---
 rtl/axis_pkt_acc_pkg.sv | 17 +
 rtl/axis_pkt_acc_if.sv | 27 ++
 rtl/axis_pkt_acc_cu.sv | 48 ++++
 rtl/axis_pkt_acc.sv | 79 +++++++
 tb/tb_axis_pkt_acc.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkt_acc_pkg.sv
// Shared definitions for the packet accumulator.
// Holds the FSM encoding and the default widths.
package axis_pkg;

    localparam logic ST_ACC  = 1'b0;
    localparam logic ST_FULL = 1'b1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic {
        S_ACC  = ST_ACC,
        S_FULL = ST_FULL
    } acc_state_e;

endpackage

// File: rtl/axis_pkt_acc_if.sv
// Beat-in / result-out stream bundle.
// The accumulator takes the slave view; its driver takes the master view.
interface axis_pkt_acc_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tlast;
    logic              s_tready;
    logic [ACC_W-1:0]  m_tdata;
    logic [CNT_W-1:0]  m_tcount;
    logic              m_tovf;
    logic              m_tvalid;
    logic              m_tready;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tcount, m_tovf, m_tvalid
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tcount, m_tovf, m_tvalid
    );
endinterface

// File: rtl/axis_pkt_acc_cu.sv
// Control unit: two-state result-slot FSM.
// Decides when beats are taken and when a result is loaded.
module axis_pkt_acc_cu
    import axis_pkg::*;
(
    input  logic aclk,
    input  logic aresetn,
    input  logic i_s_tvalid,
    input  logic i_s_tlast,
    input  logic i_m_tready,
    output logic o_s_tready,
    output logic o_m_tvalid,
    output logic o_acc_en,
    output logic o_res_load
);

    acc_state_e r_state;
    logic       w_s_tready;
    logic       w_acc_en;
    logic       w_res_load;

    // The held result drains in the same cycle a new beat enters.
    assign w_s_tready = (r_state == S_ACC) || i_m_tready;
    assign w_acc_en   = i_s_tvalid && w_s_tready;
    assign w_res_load = w_acc_en && i_s_tlast;

    assign o_s_tready = w_s_tready;
    assign o_m_tvalid = (r_state == S_FULL);
    assign o_acc_en   = w_acc_en;
    assign o_res_load = w_res_load;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_ACC;
        end else begin
            unique case (r_state)
                S_ACC: begin
                    if (w_res_load) r_state <= S_FULL;
                end
                S_FULL: begin
                    if (i_m_tready && !w_res_load) r_state <= S_ACC;
                end
                default: r_state <= S_ACC;
            endcase
        end
    end

endmodule

// File: rtl/axis_pkt_acc.sv
// Packet accumulator: sums each tlast-delimited packet and emits
// one result beat with total, saturating beat count and overflow flag.
module axis_pkt_acc
    import axis_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic          aclk,
    input  logic          aresetn,
    axis_pkt_acc_if.slave bus
);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [ACC_W-1:0] r_m_tdata;
    logic [CNT_W-1:0] r_m_tcount;
    logic             r_m_tovf;

    logic             w_acc_en;
    logic             w_res_load;
    logic             w_s_tready;
    logic             w_m_tvalid;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf_n;
    logic [CNT_W-1:0] w_cnt_n;

    axis_pkt_acc_cu u_cu (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .i_s_tvalid (bus.s_tvalid),
        .i_s_tlast  (bus.s_tlast),
        .i_m_tready (bus.m_tready),
        .o_s_tready (w_s_tready),
        .o_m_tvalid (w_m_tvalid),
        .o_acc_en   (w_acc_en),
        .o_res_load (w_res_load)
    );

    // One extra bit catches the carry that marks overflow.
    assign w_sum   = {1'b0, r_acc}
                   + {{(ACC_W + 1 - DATA_W){1'b0}}, bus.s_tdata};
    assign w_ovf_n = r_ovf | w_sum[ACC_W];
    assign w_cnt_n = (r_cnt == {CNT_W{1'b1}}) ? r_cnt
                                              : r_cnt + 1'b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tcount <= '0;
            r_m_tovf   <= 1'b0;
        end else if (w_acc_en) begin
            if (w_res_load) begin
                r_m_tdata  <= w_sum[ACC_W-1:0];
                r_m_tcount <= w_cnt_n;
                r_m_tovf   <= w_ovf_n;
                r_acc      <= '0;
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_cnt <= w_cnt_n;
                r_ovf <= w_ovf_n;
            end
        end
    end

    assign bus.s_tready = w_s_tready;
    assign bus.m_tvalid = w_m_tvalid;
    assign bus.m_tdata  = r_m_tdata;
    assign bus.m_tcount = r_m_tcount;
    assign bus.m_tovf   = r_m_tovf;

endmodule

// File: tb/tb_axis_pkt_acc.sv
// Scoreboard bench for axis_pkt_acc: three instances with different
// widths share one input stream and are checked against packet totals.
module tb_axis_pkt_acc;

    typedef struct {
        int unsigned sum;
        int unsigned n;
        longint      cyc;
    } exp_t;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] s_tdata = 8'd0;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic       m_tready = 1'b0;
    bit         rdy_force = 1'b1;
    bit         rdy_val = 1'b1;

    int          n_chk = 0;
    int          n_fail = 0;
    longint      cyc = 0;
    exp_t        q[$];
    int unsigned pkt_sum = 0;
    int unsigned pkt_n = 0;
    int          w;
    int          w3;

    bit          prev_hold = 1'b0;
    logic [63:0] held_a, held_b, held_c;

    axis_pkt_acc_if #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) ifa ();
    axis_pkt_acc_if #(.DATA_W(8), .ACC_W(8),  .CNT_W(8)) ifb ();
    axis_pkt_acc_if #(.DATA_W(8), .ACC_W(16), .CNT_W(2)) ifc ();

    assign ifa.s_tdata = s_tdata;  assign ifb.s_tdata = s_tdata;
    assign ifc.s_tdata = s_tdata;
    assign ifa.s_tvalid = s_tvalid; assign ifb.s_tvalid = s_tvalid;
    assign ifc.s_tvalid = s_tvalid;
    assign ifa.s_tlast = s_tlast;  assign ifb.s_tlast = s_tlast;
    assign ifc.s_tlast = s_tlast;
    assign ifa.m_tready = m_tready; assign ifb.m_tready = m_tready;
    assign ifc.m_tready = m_tready;

    axis_pkt_acc #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) dut_a (
        .aclk(aclk), .aresetn(aresetn), .bus(ifa));
    axis_pkt_acc #(.DATA_W(8), .ACC_W(8), .CNT_W(8)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .bus(ifb));
    axis_pkt_acc #(.DATA_W(8), .ACC_W(16), .CNT_W(2)) dut_c (
        .aclk(aclk), .aresetn(aresetn), .bus(ifc));

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk)
        m_tready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Expected result straight from the packet total and beat count.
    function automatic logic [63:0] e_data(exp_t e, int accw);
        return 64'(e.sum) % (64'd1 << accw);
    endfunction

    function automatic logic [63:0] e_cnt(exp_t e, int cntw);
        longint mx = (64'd1 << cntw) - 1;
        return (e.n > mx) ? 64'(mx) : 64'(e.n);
    endfunction

    function automatic logic [63:0] e_ovf(exp_t e, int accw);
        return (64'(e.sum) > (64'd1 << accw) - 1) ? 64'd1 : 64'd0;
    endfunction

    always @(negedge aclk) begin
        #2;
        if (!aresetn) begin
            prev_hold = 1'b0;
        end else begin
            logic exp_v;
            exp_v = (q.size() > 0) && (cyc >= q[0].cyc);
            chk("valid_a", ifa.m_tvalid, exp_v);
            chk("valid_b", ifb.m_tvalid, exp_v);
            chk("valid_c", ifc.m_tvalid, exp_v);
            chk("ready_b", ifb.s_tready, ifa.s_tready);
            chk("ready_c", ifc.s_tready, ifa.s_tready);
            if (prev_hold) begin
                chk("hold_a", 64'(ifa.m_tdata), held_a);
                chk("hold_b", 64'(ifb.m_tdata), held_b);
                chk("hold_c", 64'(ifc.m_tcount), held_c);
            end
            prev_hold = ifa.m_tvalid && !m_tready;
            held_a = 64'(ifa.m_tdata);
            held_b = 64'(ifb.m_tdata);
            held_c = 64'(ifc.m_tcount);
            if (ifa.m_tvalid && m_tready && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("data_a", 64'(ifa.m_tdata), e_data(e, 16));
                chk("cnt_a", 64'(ifa.m_tcount), e_cnt(e, 8));
                chk("ovf_a", 64'(ifa.m_tovf), e_ovf(e, 16));
                chk("data_b", 64'(ifb.m_tdata), e_data(e, 8));
                chk("ovf_b", 64'(ifb.m_tovf), e_ovf(e, 8));
                chk("data_c", 64'(ifc.m_tdata), e_data(e, 16));
                chk("cnt_c", 64'(ifc.m_tcount), e_cnt(e, 2));
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input bit last,
                             output int waits);
        waits = 0;
        @(negedge aclk);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        #1;
        while (!ifa.s_tready) begin
            waits++;
            if (waits > 200) begin
                chk("beat_timeout", 64'(waits), 64'd0);
                break;
            end
            @(negedge aclk);
            #1;
        end
        if (waits <= 200) begin
            pkt_sum += d;
            pkt_n++;
            if (last) begin
                q.push_back('{sum: pkt_sum, n: pkt_n, cyc: cyc + 1});
                pkt_sum = 0;
                pkt_n = 0;
            end
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tdata  = 8'($urandom);
        s_tlast  = 1'($urandom);
    endtask

    task automatic do_reset();
        #2;
        aresetn = 1'b0;
        #1;
        chk("rst_valid_a", ifa.m_tvalid, 1'b0);
        chk("rst_valid_b", ifb.m_tvalid, 1'b0);
        chk("rst_data_a", 64'(ifa.m_tdata), 64'd0);
        chk("rst_cnt_a", 64'(ifa.m_tcount), 64'd0);
        chk("rst_ovf_a", ifa.m_tovf, 1'b0);
        q.delete();
        pkt_sum = 0;
        pkt_n = 0;
        repeat (2) @(negedge aclk);
        #3;
        aresetn = 1'b1;
        #1;
        chk("rst_sready", ifa.s_tready, 1'b1);
    endtask

    initial begin
        rdy_force = 1'b1;
        rdy_val = 1'b1;
        aresetn = 1'b0;
        #1;
        chk("init_valid", ifa.m_tvalid, 1'b0);
        chk("init_data", 64'(ifa.m_tdata), 64'd0);
        repeat (2) @(negedge aclk);
        #3;
        aresetn = 1'b1;
        #1;
        chk("init_sready", ifa.s_tready, 1'b1);

        send_beat(8'd3, 1'b0, w);
        send_beat(8'd5, 1'b0, w);
        send_beat(8'd7, 1'b1, w);
        chk("p1_valid", ifa.m_tvalid, 1'b1);
        chk("p1_data", 64'(ifa.m_tdata), 64'd15);
        chk("p1_cnt", 64'(ifa.m_tcount), 64'd3);
        chk("p1_ovf", ifa.m_tovf, 1'b0);

        send_beat(8'd9, 1'b1, w);
        chk("b2b_wait0", 64'(w), 64'd0);
        send_beat(8'd4, 1'b1, w);
        chk("b2b_wait1", 64'(w), 64'd0);
        chk("b2b_data", 64'(ifa.m_tdata), 64'd4);
        chk("b2b_cnt", 64'(ifa.m_tcount), 64'd1);

        send_beat(8'd10, 1'b0, w);
        send_beat(8'd20, 1'b1, w);
        rdy_val = 1'b0;
        fork
            send_beat(8'd1, 1'b1, w3);
        join_none
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            #1;
            chk("stall_sready", ifa.s_tready, 1'b0);
            chk("stall_data", 64'(ifa.m_tdata), 64'd30);
        end
        rdy_val = 1'b1;
        wait fork;
        chk("stall_waited", 64'(w3 >= 4), 64'd1);

        send_beat(8'd200, 1'b0, w);
        send_beat(8'd100, 1'b0, w);
        send_beat(8'd10, 1'b1, w);
        chk("ovf_data_b", 64'(ifb.m_tdata), 64'd54);
        chk("ovf_flag_b", ifb.m_tovf, 1'b1);
        send_beat(8'd1, 1'b1, w);
        chk("ovf_clr_b", ifb.m_tovf, 1'b0);

        for (int i = 0; i < 5; i++) send_beat(8'd1, i == 4, w);
        chk("sat_cnt_c", 64'(ifc.m_tcount), 64'd3);
        chk("sat_data_c", 64'(ifc.m_tdata), 64'd5);

        send_beat(8'd2, 1'b0, w);
        send_beat(8'd3, 1'b0, w);
        do_reset();
        rdy_val = 1'b0;
        send_beat(8'd5, 1'b1, w);
        chk("rst2_pre_valid", ifa.m_tvalid, 1'b1);
        do_reset();
        rdy_val = 1'b1;
        send_beat(8'd2, 1'b0, w);
        send_beat(8'd2, 1'b1, w);
        chk("rst2_data", 64'(ifa.m_tdata), 64'd4);
        chk("rst2_cnt", 64'(ifa.m_tcount), 64'd2);

        rdy_force = 1'b0;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++)
                send_beat(8'($urandom), b == len - 1, w);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge aclk);
        end

        rdy_force = 1'b1;
        rdy_val = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            @(negedge aclk);
        end
        #3;
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
